// File: rtl/board_draw.sv
// board_draw: paints the cells of a 2**Y_ADDR_WIDTH x 2**X_ADDR_WIDTH game board
// onto the VGA stream. For each pixel it derives the cell under the pixel from the
// counters, fetches that cell's state from board_mem, and recolours the pixel.
// All VGA signals leave exactly 3 clocks after they arrive.
// Optional feature macro: HIT_BLINK_EN makes "hit" cells blink every BLINK_FRAMES frames.
module board_draw #(
  parameter logic [10:0] XPOS         = 11'd100,
  parameter logic [10:0] YPOS         = 11'd100,
  parameter int          CELL_LOG2    = 5,
  parameter int          X_ADDR_WIDTH = 4,
  parameter int          Y_ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH   = 2,
  parameter logic [11:0] C_WATER      = 12'h00F,
  parameter logic [11:0] C_SHIP       = 12'h888,
  parameter logic [11:0] C_MISS       = 12'hFFF,
  parameter logic [11:0] C_HIT        = 12'hF00
`ifdef HIT_BLINK_EN
  ,
  parameter int          BLINK_FRAMES = 30
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [10:0]                          hcount_in,
  input  logic                                 hsync_in,
  input  logic                                 hblnk_in,
  input  logic [10:0]                          vcount_in,
  input  logic                                 vsync_in,
  input  logic                                 vblnk_in,
  input  logic [11:0]                          rgb_in,
  output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0]                read_data,
  output logic [10:0]                          hcount_out,
  output logic                                 hsync_out,
  output logic                                 hblnk_out,
  output logic [10:0]                          vcount_out,
  output logic                                 vsync_out,
  output logic                                 vblnk_out,
  output logic [11:0]                          rgb_out
);

  // Board rectangle; upper bounds are exclusive so the last pixel of the last cell is inside.
  localparam int X_END = int'(XPOS) + ((2 ** X_ADDR_WIDTH) << CELL_LOG2);
  localparam int Y_END = int'(YPOS) + ((2 ** Y_ADDR_WIDTH) << CELL_LOG2);

  // VGA signals travelling down the pipeline together.
  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t                    w_vga_in;
  vga_t                    r1_vga;
  vga_t                    r2_vga;
  logic                    r1_in_board;
  logic                    r2_in_board;
  logic                    w_in_board;
  logic [X_ADDR_WIDTH-1:0] w_col;
  logic [Y_ADDR_WIDTH-1:0] w_row;
  logic [11:0]             w_hit_rgb;
  logic [11:0]             w_cell_rgb;

  assign w_vga_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                      vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in, rgb: rgb_in};

  // Cell indices come from 11-bit offsets by shifting only; no divider is needed.
  assign w_in_board = !hblnk_in && !vblnk_in &&
                      (int'(hcount_in) >= int'(XPOS)) && (int'(hcount_in) < X_END) &&
                      (int'(vcount_in) >= int'(YPOS)) && (int'(vcount_in) < Y_END);
  assign w_col = X_ADDR_WIDTH'((hcount_in - XPOS) >> CELL_LOG2);
  assign w_row = Y_ADDR_WIDTH'((vcount_in - YPOS) >> CELL_LOG2);

  // Stage 1: locate the cell and issue the board_mem read; hold the address outside the board.
  // NOTE: reset is synchronous here, so rst appears only inside the clocked block, never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vga      <= '0;
      r1_in_board <= 1'b0;
      read_addr   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every stage reading the previous cycle's values.
      r1_vga      <= w_vga_in;
      r1_in_board <= w_in_board;
      if (w_in_board) read_addr <= {w_row, w_col};
    end
  end

  // Stage 2: wait for board_mem to return the cell state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_vga      <= '0;
      r2_in_board <= 1'b0;
    end else begin
      r2_vga      <= r1_vga;
      r2_in_board <= r1_in_board;
    end
  end

`ifdef HIT_BLINK_EN
  localparam int BLINK_CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_CW-1:0] r_blink_cnt;
  logic                r_blink_phase;
  logic                r_vsync_prev;

  // Frame counter advancing on each vsync rising edge; the phase flips when it wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_vsync_prev  <= 1'b0;
    end else begin
      r_vsync_prev <= vsync_in;
      if (vsync_in && !r_vsync_prev) begin
        if (r_blink_cnt == BLINK_CW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign w_hit_rgb = r_blink_phase ? C_WATER : C_HIT;
`else
  assign w_hit_rgb = C_HIT;
`endif

  // Map the returned cell state to its colour.
  always_comb begin
    // NOTE: the default assignment first guarantees no latch for unlisted states.
    w_cell_rgb = C_WATER;
    case (read_data)
      DATA_WIDTH'(1): w_cell_rgb = C_SHIP;
      DATA_WIDTH'(2): w_cell_rgb = C_MISS;
      DATA_WIDTH'(3): w_cell_rgb = w_hit_rgb;
      default:        w_cell_rgb = C_WATER;
    endcase
  end

  // Stage 3: paint board pixels, pass everything else through.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= r2_vga.hcount;
      hsync_out  <= r2_vga.hsync;
      hblnk_out  <= r2_vga.hblnk;
      vcount_out <= r2_vga.vcount;
      vsync_out  <= r2_vga.vsync;
      vblnk_out  <= r2_vga.vblnk;
      rgb_out    <= r2_in_board ? w_cell_rgb : r2_vga.rgb;
    end
  end

endmodule

// File: tb/tb_board_draw.sv
// Testbench for board_draw: a synchronous-read board memory model feeds the DUT, and a
// scoreboard queue holds the expected outputs of each pixel until they emerge 3 clocks later.
module tb_board_draw;

  localparam int XP   = 100;
  localparam int YP   = 100;
  localparam int CELL = 32;
  localparam int BPX  = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_in, rgb_out;
  logic [7:0]  read_addr;
  logic [1:0]  read_data;

  always #5 clk = ~clk;

`ifdef HIT_BLINK_EN
  board_draw #(.BLINK_FRAMES(2)) dut (
`else
  board_draw dut (
`endif
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .read_addr(read_addr), .read_data(read_data),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // board_mem read port: data valid one clock after the address.
  logic [1:0] mem [256];
  always @(posedge clk) read_data <= mem[read_addr];

  typedef struct {
    logic [11:0] rgb;
    logic [25:0] vga;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_addr = 8'h00;
  logic [11:0] exp_hit_rgb = 12'hF00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] colour(input logic [1:0] s);
    case (s)
      2'd0:    return 12'h00F;
      2'd1:    return 12'h888;
      2'd2:    return 12'hFFF;
      default: return exp_hit_rgb;
    endcase
  endfunction

  // Compare whatever the DUT presents now against the oldest in-flight expectation.
  task automatic sample_and_check();
    exp_t e;
    check("read_addr", 64'(read_addr), 64'(ref_addr));
    if (sb_q.size() == 3) begin
      e = sb_q.pop_front();
      check("rgb_out", 64'(rgb_out), 64'(e.rgb));
      check("vga_out", 64'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}),
            64'(e.vga));
    end
  endtask

  // Drive one pixel and push its expected outputs.
  task automatic drive_push(input int h, input int v, input bit hb, input bit vb,
                            input bit hs, input bit vs);
    exp_t       e;
    logic [11:0] bg;
    bit         inb;
    bg        = 12'($urandom);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    vblnk_in  = vb;
    hsync_in  = hs;
    vsync_in  = vs;
    rgb_in    = bg;
    inb = !hb && !vb && h >= XP && h < XP + BPX && v >= YP && v < YP + BPX;
    if (inb) begin
      ref_addr = 8'(((v - YP) / CELL) * 16 + (h - XP) / CELL);
      e.rgb    = colour(mem[ref_addr]);
    end else begin
      e.rgb = bg;
    end
    e.vga = {11'(h), hs, hb, 11'(v), vs, vb};
    sb_q.push_back(e);
  endtask

  task automatic step(input int h, input int v, input bit hb = 0, input bit vb = 0,
                      input bit hs = 0, input bit vs = 0);
    @(negedge clk);
    sample_and_check();
    drive_push(h, v, hb, vb, hs, vs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b1, 1'b1);
  endtask

  // Hold rst for 5 clocks while a line keeps running; every output must read 0.
  task automatic do_reset(input int h0, input int v);
    @(negedge clk);
    rst = 1'b1;
    hcount_in = 11'(h0);
    vcount_in = 11'(v);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("rst_outs", 64'({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out,
                             vblnk_out, rgb_out, read_addr}), 64'd0);
      hcount_in = 11'(h0 + i);
      rgb_in    = 12'($urandom);
    end
    sb_q.delete();
    ref_addr    = 8'h00;
    exp_hit_rgb = 12'hF00;
    rst = 1'b0;
    drive_push(h0 + 6, v, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 2'(a);
    mem[8'h23] = 2'b01;
    rst = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 1; vblnk_in = 1; rgb_in = '0;

    do_reset(0, 0);
    idle(3);

`ifdef HIT_BLINK_EN
    // Hit cell at (r0,c0) blinks with two frames per phase.
    mem[0] = 2'b11;
    for (int f = 0; f < 6; f++) begin
      exp_hit_rgb = ((f / 2) % 2 == 1) ? 12'h00F : 12'hF00;
      step(XP + 5, YP + 5);
      idle(3);
      check("blink_frame", 64'(rgb_out), 64'(exp_hit_rgb));
      step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(1);
    end
    mem[0] = 2'b00;
`endif

    // Reset mid-line inside the board.
    for (int h = XP + 40; h < XP + 60; h++) step(h, YP + 10);
    do_reset(XP + 60, YP + 10);
    for (int h = XP + 67; h < XP + 90; h++) step(h, YP + 10);
    idle(3);

    // Preloaded ship cell at row 2, column 3.
    step(XP + 3 * CELL, YP + 2 * CELL);
    step(0, 0, 1'b1, 1'b1);
    check("addr_r2c3", 64'(read_addr), 64'h23);
    idle(2);
    check("rgb_r2c3", 64'(rgb_out), 64'h888);
    idle(3);

    // Horizontal boundaries on board row 0.
    step(XP - 1, YP);
    step(XP + BPX, YP);
    step(XP + BPX - 1, YP);
    step(0, 0, 1'b1, 1'b1);
    check("addr_c15", 64'(read_addr), 64'h0F);
    idle(3);

    // Horizontal blank inside the board holds the address and passes rgb_in.
    step(XP + 100, YP + 100);
    step(XP + 200, YP + 100, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b1);
    check("addr_hblnk", 64'(read_addr), 64'h33);
    idle(3);

    // Scan one line through every board row, spanning both edges.
    for (int r = 0; r < 16; r++) begin
      for (int h = XP - 2; h < XP + BPX + 2; h++) step(h, YP + r * CELL + (r * 7) % CELL);
      idle(4);
    end
    // Lines just above and just below the board.
    for (int h = XP - 2; h < XP + 40; h++) step(h, YP - 1);
    for (int h = XP - 2; h < XP + 40; h++) step(h, YP + BPX);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
